fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 25 ++
 rtl/pc_next.sv | 29 ++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcode constants, canonical NOP, fetch FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_WAIT  = 3'd2,
    F_HOLD  = 3'd3,
    F_FAULT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select with alignment handling.
// FETCH_MISALIGN_CHECK_EN: pass target through and flag low-bit misalignment;
// otherwise the low two bits are forced to zero and no fault is ever raised.
module pc_next
  import riscv_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] sel;

  // Wraps modulo 2^32; no overflow indication.
  assign pc_plus4_o = pc_i + 32'd4;
  assign sel        = pc_src_i ? pc_target_i : pc_plus4_o;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign next_pc_o    = sel;
  assign misaligned_o = (sel[1:0] != 2'b00);
`else
  assign next_pc_o    = sel & ~32'h3;
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, buffered instruction
// presented to decode with valid/ready, PC+4 or redirect on retire.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-target fault.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  npc;
  logic         npc_misaligned;

  pc_next u_pc_next (
    .pc_i         (pc_q),
    .pc_src_i     (pc_src),
    .pc_target_i  (pc_target),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (npc),
    .misaligned_o (npc_misaligned)
  );

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic; rvalid/ready/redirect only matter in their own states.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      F_IDLE: state_d = F_REQ;
      F_REQ:  state_d = F_WAIT;
      F_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = F_HOLD;
        end
      end
      F_HOLD: begin
        if (instr_ready) begin
          pc_d    = npc;
          state_d = npc_misaligned ? F_FAULT : F_REQ;
        end
      end
      F_FAULT: state_d = F_FAULT;
      default: state_d = F_IDLE;
    endcase
  end

  assign imem_req    = (state_q == F_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == F_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign pc          = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (state_q == F_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs sampled 1 time unit
// after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op(op), .pc(pc), .pc_plus4(pc_plus4),
    .pc_src(pc_src), .pc_target(pc_target), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
  endtask

  // Full set of reset-value checks, tagged with where they were taken.
  task automatic check_reset_vals(input string tag);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL %s imem_req got %b want 0", tag, imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL %s imem_addr got %h want 0", tag, imem_addr); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL %s pc got %h want 0", tag, pc); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL %s pc_plus4 got %h want 4", tag, pc_plus4); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL %s instr got %h want 13", tag, instr); end
    n_cmp++; if (op !== 7'b0010011) begin n_err++; $display("FAIL %s op got %b want 0010011", tag, op); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL %s instr_valid got %b want 0", tag, instr_valid); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL %s fetch_fault got %b want 0", tag, fetch_fault); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst_n = 1'b1;              // released just after an edge: now in IDLE
    check_reset_vals("idle");
  endtask

  // First fetch: req at 0, rvalid one cycle later, valid two cycles after req.
  task automatic test_first_fetch();
    step();                    // REQ
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got %h want 0", imem_addr); end
    step();                    // WAIT
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL req_pulse got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid got %b want 0", instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    step();                    // HOLD
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", instr_valid); end
    n_cmp++; if (instr !== 32'h0000_0033) begin n_err++; $display("FAIL first_instr got %h want 33", instr); end
    n_cmp++; if (op !== 7'b0110011) begin n_err++; $display("FAIL first_op got %b want 0110011", op); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL first_pc_plus4 got %h want 4", pc_plus4); end
  endtask

  // Stall in HOLD for 5 cycles, then sequential retire to PC+4.
  task automatic test_hold_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (instr !== 32'h0000_0033 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall%0d instr=%h pc=%h req=%b valid=%b want 33/0/0/1", i, instr, pc, imem_req, instr_valid);
      end
    end
    instr_ready = 1'b1; pc_src = 1'b0;
    step();                    // REQ at 4
    instr_ready = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL seq_req req=%b addr=%h want 1/4", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid got %b want 0", instr_valid); end
  endtask

  // Redirect to 0x100, then a 4-cycle memory latency with a single req pulse.
  task automatic test_redirect_latency();
    int reqs;
    step();                    // WAIT at 4
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    step();                    // HOLD
    imem_rvalid = 1'b0;
    n_cmp++; if (op !== 7'b1101111) begin n_err++; $display("FAIL jal_op got %b want 1101111", op); end
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0100;
    step();                    // REQ at 0x100
    idle_inputs();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_req req=%b addr=%h want 1/100", imem_req, imem_addr); end
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (imem_req) reqs++;
    end
    n_cmp++; if (reqs != 0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL latency_wait extra_reqs=%0d valid=%b want 0/0", reqs, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063;
    step();                    // HOLD
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0063 || pc !== 32'h100) begin
      n_err++; $display("FAIL latency_hold valid=%b instr=%h pc=%h want 1/63/100", instr_valid, instr, pc);
    end
  endtask

  // Spurious rvalid in HOLD, then PC wrap from 0xFFFFFFFC to 0.
  task automatic test_spurious_and_wrap();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr !== 32'h0000_0063) begin n_err++; $display("FAIL spurious_rvalid instr got %h want 63", instr); end
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    step();                    // REQ at FFFFFFFC
    idle_inputs();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL top_addr got %h want fffffffc", imem_addr); end
    step();                    // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();                    // HOLD
    imem_rvalid = 1'b0;
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus4 got %h want 0", pc_plus4); end
    instr_ready = 1'b1; pc_src = 1'b0;
    step();                    // REQ at 0
    idle_inputs();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_req req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  // Misaligned redirect target 0x102.
  task automatic test_misaligned();
    step();                    // WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0067;
    step();                    // HOLD
    imem_rvalid = 1'b0;
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0102;
    step();
    idle_inputs();
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h102) begin
      n_err++; $display("FAIL misalign_fault fault=%b valid=%b req=%b pc=%h want 1/0/0/102", fetch_fault, instr_valid, imem_req, pc);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL fault_sticky%0d fault=%b req=%b want 1/0", i, fetch_fault, imem_req); end
    end
    instr_ready = 1'b0;
`else
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL misalign_force req=%b addr=%h fault=%b want 1/100/0", imem_req, imem_addr, fetch_fault);
    end
`endif
  endtask

  // Reset asserted in WAIT; late response arriving in IDLE must be dropped.
  task automatic test_reset_in_wait();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();                    // REQ at 0
    step();                    // WAIT
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL pre_wait req=%b valid=%b want 0/0", imem_req, instr_valid); end
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    step();
    rst_n = 1'b1;              // IDLE; stale response shows up now
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();                    // REQ
    imem_rvalid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL fresh_req req=%b addr=%h want 1/0", imem_req, imem_addr); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL stale_drop instr got %h want 13", instr); end
    step();                    // WAIT
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin n_err++; $display("FAIL stale_wait valid=%b instr=%h want 0/13", instr_valid, instr); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_latency();
    test_spurious_and_wrap();
    test_misaligned();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
